// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register.
// Merges two-word (opcode + immediate) instructions into one entry.
module fetch_stage #(
  parameter int ADDR_W = 20,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  output logic [4:0]        id_opcode,
  output logic [2:0]        id_rdst,
  output logic [2:0]        id_rsrc,
  output logic [15:0]       id_imm,
  output logic [ADDR_W-1:0] id_pc
);

  typedef enum logic {
    FETCH_OP,
    FETCH_IMM
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W-1:0] op_pc, op_pc_n;
  logic [15:0]       opword, opword_n;
  logic              valid_n;
  logic [4:0]        opcode_n;
  logic [2:0]        rdst_n, rsrc_n;
  logic [15:0]       imm_n;
  logic [ADDR_W-1:0] idpc_n;
  logic [4:0]        op;
  logic              two_word;

  assign imem_addr = pc;
  assign op        = imem_data[15:11];
  assign two_word  = (op == 5'd13) || (op == 5'd30) || (op == 5'd31);

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    op_pc_n  = op_pc;
    opword_n = opword;
    valid_n  = id_valid;
    opcode_n = id_opcode;
    rdst_n   = id_rdst;
    rsrc_n   = id_rsrc;
    imm_n    = id_imm;
    idpc_n   = id_pc;
    if (redirect) begin
      // squashed entry must decode as NOP downstream
      pc_n     = redirect_pc;
      state_n  = FETCH_OP;
      opword_n = '0;
      valid_n  = 1'b0;
      opcode_n = '0;
      rdst_n   = '0;
      rsrc_n   = '0;
      imm_n    = '0;
    end else if (!stall) begin
      pc_n = pc + ADDR_W'(1);
      unique case (state)
        FETCH_OP: begin
          if (two_word) begin
            opword_n = imem_data;
            op_pc_n  = pc;
            state_n  = FETCH_IMM;
            valid_n  = 1'b0;
            opcode_n = '0;
            rdst_n   = '0;
            rsrc_n   = '0;
            imm_n    = '0;
          end else begin
            valid_n  = 1'b1;
            opcode_n = imem_data[15:11];
            rdst_n   = imem_data[10:8];
            rsrc_n   = imem_data[7:5];
            imm_n    = '0;
            idpc_n   = pc;
          end
        end
        FETCH_IMM: begin
          valid_n  = 1'b1;
          opcode_n = opword[15:11];
          rdst_n   = opword[10:8];
          rsrc_n   = opword[7:5];
          imm_n    = imem_data;
          idpc_n   = op_pc;
          state_n  = FETCH_OP;
        end
        default: state_n = FETCH_OP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH_OP;
      pc        <= RESET_PC;
      op_pc     <= '0;
      opword    <= '0;
      id_valid  <= 1'b0;
      id_opcode <= '0;
      id_rdst   <= '0;
      id_rsrc   <= '0;
      id_imm    <= '0;
      id_pc     <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      op_pc     <= op_pc_n;
      opword    <= opword_n;
      id_valid  <= valid_n;
      id_opcode <= opcode_n;
      id_rdst   <= rdst_n;
      id_rsrc   <= rsrc_n;
      id_imm    <= imm_n;
      id_pc     <= idpc_n;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, corner sequences,
// and random stall/redirect traffic checked against an instruction-stream model.
module tb_fetch_stage;

  logic        clk = 0;
  logic        rst = 1;
  logic [19:0] imem_addr;
  logic [15:0] imem_data = '0;
  logic        stall = 0;
  logic        redirect = 0;
  logic [19:0] redirect_pc = '0;
  logic        id_valid;
  logic [4:0]  id_opcode;
  logic [2:0]  id_rdst;
  logic [2:0]  id_rsrc;
  logic [15:0] id_imm;
  logic [19:0] id_pc;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] mem [logic [19:0]];

  fetch_stage #(.ADDR_W(20), .RESET_PC(20'h0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_rdst(id_rdst),
    .id_rsrc(id_rsrc), .id_imm(id_imm), .id_pc(id_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memrd(logic [19:0] a);
    if ($isunknown(a)) return 16'h0;
    if (mem.exists(a)) return mem[a];
    return 16'(a * 20'h9E37 + 20'h1111);
  endfunction

  function automatic bit is2(logic [15:0] w);
    return w[15:11] == 5'd13 || w[15:11] == 5'd30 || w[15:11] == 5'd31;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(bit r, bit s, bit rd, logic [19:0] rpc);
    rst = r;
    stall = s;
    redirect = rd;
    redirect_pc = rpc;
    imem_data = memrd(imem_addr);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          r, s, rd;
    logic [19:0] rpc;
    logic [19:0] addr;
    bit          v;
    logic [4:0]  op;
    logic [2:0]  rdst, rsrc;
    logic [15:0] imm;
    logic [19:0] pc;
    bit          cpc;
  } vec_t;

  vec_t tbl[20];

  // random-phase model state
  logic [19:0] wa;
  bit          pend;
  logic [15:0] w0, w1;
  logic [31:0] prev;

  initial begin
    mem[20'h00000] = 16'hC900;
    mem[20'h00001] = 16'h1800;
    mem[20'h00002] = 16'h6A00;
    mem[20'h00003] = 16'h1234;
    mem[20'h00004] = 16'h6C00;
    mem[20'h00005] = 16'hABCD;
    mem[20'h00006] = 16'hF300;
    mem[20'h00040] = 16'h08E0;
    mem[20'hFFFFF] = 16'h2100;

    //        r s rd rpc       addr      v op  rd rs imm      pc       cpc
    tbl[0]  = '{1,0,0,20'h0,   20'h0,    0,0,  0, 0, 16'h0,   20'h0,   1};
    tbl[1]  = '{0,0,0,20'h0,   20'h1,    1,25, 1, 0, 16'h0,   20'h0,   1};
    tbl[2]  = '{0,0,0,20'h0,   20'h2,    1,3,  0, 0, 16'h0,   20'h1,   1};
    tbl[3]  = '{0,0,0,20'h0,   20'h3,    0,0,  0, 0, 16'h0,   20'h0,   0};
    tbl[4]  = '{0,0,0,20'h0,   20'h4,    1,13, 2, 0, 16'h1234,20'h2,   1};
    tbl[5]  = '{0,0,0,20'h0,   20'h5,    0,0,  0, 0, 16'h0,   20'h0,   0};
    tbl[6]  = '{0,1,0,20'h0,   20'h5,    0,0,  0, 0, 16'h0,   20'h0,   0};
    tbl[7]  = '{0,1,0,20'h0,   20'h5,    0,0,  0, 0, 16'h0,   20'h0,   0};
    tbl[8]  = '{0,1,0,20'h0,   20'h5,    0,0,  0, 0, 16'h0,   20'h0,   0};
    tbl[9]  = '{0,0,0,20'h0,   20'h6,    1,13, 4, 0, 16'hABCD,20'h4,   1};
    tbl[10] = '{0,0,0,20'h0,   20'h7,    0,0,  0, 0, 16'h0,   20'h0,   0};
    tbl[11] = '{0,1,1,20'h40,  20'h40,   0,0,  0, 0, 16'h0,   20'h0,   0};
    tbl[12] = '{0,0,0,20'h0,   20'h41,   1,1,  0, 7, 16'h0,   20'h40,  1};
    tbl[13] = '{0,0,1,20'hFFFFF,20'hFFFFF,0,0, 0, 0, 16'h0,   20'h0,   0};
    tbl[14] = '{0,0,0,20'h0,   20'h0,    1,4,  1, 0, 16'h0,   20'hFFFFF,1};
    tbl[15] = '{0,0,1,20'h2,   20'h2,    0,0,  0, 0, 16'h0,   20'h0,   0};
    tbl[16] = '{0,0,0,20'h0,   20'h3,    0,0,  0, 0, 16'h0,   20'h0,   0};
    tbl[17] = '{1,0,0,20'h0,   20'h0,    0,0,  0, 0, 16'h0,   20'h0,   1};
    tbl[18] = '{0,0,0,20'h0,   20'h1,    1,25, 1, 0, 16'h0,   20'h0,   1};
    tbl[19] = '{0,1,0,20'h0,   20'h1,    1,25, 1, 0, 16'h0,   20'h0,   1};

    step(1, 0, 0, '0);
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].rd, tbl[i].rpc);
      chk($sformatf("v%0d.addr", i), 32'(imem_addr), 32'(tbl[i].addr));
      chk($sformatf("v%0d.valid", i), 32'(id_valid), 32'(tbl[i].v));
      chk($sformatf("v%0d.op", i), 32'(id_opcode), 32'(tbl[i].op));
      chk($sformatf("v%0d.rdst", i), 32'(id_rdst), 32'(tbl[i].rdst));
      chk($sformatf("v%0d.rsrc", i), 32'(id_rsrc), 32'(tbl[i].rsrc));
      chk($sformatf("v%0d.imm", i), 32'(id_imm), 32'(tbl[i].imm));
      if (tbl[i].cpc)
        chk($sformatf("v%0d.idpc", i), 32'(id_pc), 32'(tbl[i].pc));
    end

    // two-word instruction at the top address takes its immediate from 0
    mem[20'hFFFFF] = 16'hF860;
    step(0, 0, 1, 20'hFFFFF);
    step(0, 0, 0, '0);
    chk("wrap2.bubble", 32'(id_valid), 32'(0));
    chk("wrap2.addr0", 32'(imem_addr), 32'(0));
    step(0, 0, 0, '0);
    chk("wrap2.valid", 32'(id_valid), 32'(1));
    chk("wrap2.ins", {id_opcode, id_rdst, id_rsrc, id_imm},
        {5'd31, 3'd0, 3'd3, 16'hC900});
    chk("wrap2.idpc", 32'(id_pc), 32'hFFFFF);
    chk("wrap2.addr", 32'(imem_addr), 32'(1));

    // random traffic: outputs must replay the program from the walk address
    for (int a = 'h100; a < 'h180; a++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0: w[15:11] = 5'd13;
          1: w[15:11] = 5'd30;
          default: w[15:11] = 5'd31;
        endcase
      end
      mem[20'(a)] = w;
    end
    step(1, 0, 0, '0);
    wa = 20'h0;
    pend = 0;
    prev = '0;
    for (int c = 0; c < 600; c++) begin
      bit s, rd;
      logic [19:0] rpc;
      s = ($urandom_range(0, 3) == 0);
      rd = (c == 0) || ($urandom_range(0, 15) == 0);
      rpc = 20'h100 + 20'($urandom_range(0, 47));
      step(0, s, rd, rpc);
      if (rd) begin
        wa = rpc;
        pend = 0;
        chk("rnd.redir_valid", 32'(id_valid), 32'(0));
        chk("rnd.redir_op", 32'(id_opcode), 32'(0));
      end else if (s) begin
        chk("rnd.stall_hold", {id_valid, id_opcode, id_rdst, id_rsrc, id_imm},
            prev);
      end else if (id_valid) begin
        w0 = memrd(wa);
        w1 = is2(w0) ? memrd(wa + 20'd1) : 16'h0;
        chk("rnd.ins", {id_opcode, id_rdst, id_rsrc, id_imm},
            {w0[15:11], w0[10:8], w0[7:5], w1});
        chk("rnd.idpc", 32'(id_pc), 32'(wa));
        wa = wa + (is2(w0) ? 20'd2 : 20'd1);
        pend = 0;
      end else begin
        chk("rnd.bubble_legal", 32'({pend, is2(memrd(wa))}), 32'(1));
        chk("rnd.bubble_nop", {id_opcode, id_rdst, id_rsrc, id_imm}, 32'(0));
        pend = 1;
      end
      chk("rnd.addr", 32'(imem_addr), 32'(wa + (pend ? 20'd1 : 20'd0)));
      prev = {id_valid, id_opcode, id_rdst, id_rsrc, id_imm};
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
